// File: rtl/param_data_mem.sv
// Parametrised single-port data memory with init sequencer and range check.
// Optional even-parity protection per word when PARITY_EN is defined.
module param_data_mem #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       DEPTH    = 24,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err,
    output logic                init_done,
    output logic                perr
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] init_cnt;
    logic              init_last;
    logic              init_we;

    logic              acc;
    logic              acc_wr;
    logic              acc_rd;
    logic              in_range;

    logic [IDX_W-1:0]  addr_idx;
    logic [IDX_W-1:0]  init_idx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_word;

    logic              perr_d;

    assign init_last = (init_cnt == LAST_A);
    assign in_range  = ({1'b0, addr} < DEPTH_X);
    assign addr_idx  = addr[IDX_W-1:0];
    assign init_idx  = init_cnt[IDX_W-1:0];

    assign acc    = req && ready;
    assign acc_wr = acc && we;
    assign acc_rd = acc && !we;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT: begin
                if (init_last) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        ready     = 1'b0;
        init_done = 1'b0;
        init_we   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                init_we = 1'b1;
            end
            S_IDLE: begin
                ready     = 1'b1;
                init_done = 1'b1;
            end
            default: begin
                init_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= '0;
        end else if (state_q == S_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Byte-lane merge against the currently stored word
    always_comb begin
        merged = mem[addr_idx];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = init_idx;
        wr_word = INIT_VAL;
        if (init_we) begin
            wr_en = 1'b1;
        end else if (acc_wr && in_range) begin
            wr_en   = 1'b1;
            wr_idx  = addr_idx;
            wr_word = merged;
        end
    end

    // Array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
    end

`ifdef PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[wr_idx] <= ^wr_word;
        end
    end

    assign perr_d = in_range &&
                    ((^mem[addr_idx]) != par_mem[addr_idx]);
`else
    assign perr_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            perr   <= 1'b0;
        end else begin
            rvalid <= acc_rd;
            err    <= acc && !in_range;
            perr   <= acc_rd && perr_d;
            if (acc_rd) begin
                rdata <= in_range ? mem[addr_idx] : '0;
            end
        end
    end

endmodule
